tjmonopix2_rx_packer: RTL and testbench

Frame packer between the FPGA-side 8b10b decoder of the TJ-Monopix2 serial data link and the readout arbiter that feeds the BRAM FIFO. It takes decoded bytes with a K-character flag, tracks chip frame boundaries, and packs payload bytes three per 32-bit word with an identifier and framing flags. It buffers the words in a small first-word-fall-through FIFO, and counts lost words and framing errors.

---
 rtl/tjmonopix2_rx_pkg.sv | 37 +++
 rtl/rx_packer_fifo.sv | 56 +++++
 rtl/tjmonopix2_rx_packer.sv | 173 +++++++++++++++++
 tb/tb_tjmonopix2_rx_packer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tjmonopix2_rx_pkg.sv
// Shared definitions for the TJ-Monopix2 receive-side frame packer.
//   - K-character codes seen on the decoded 8b10b byte stream
//   - bit offsets of the 32-bit packed word
//   - packer FSM state type and a word-assembly helper
package tjmonopix2_rx_pkg;

    localparam logic [7:0] K_IDLE = 8'hBC;  // K28.5
    localparam logic [7:0] K_SOF  = 8'h3C;  // K28.1
    localparam logic [7:0] K_EOF  = 8'h1C;  // K28.0

    localparam int unsigned W_ID_LSB    = 28;
    localparam int unsigned W_SOF_BIT   = 27;
    localparam int unsigned W_EOF_BIT   = 26;
    localparam int unsigned W_NB_LSB    = 24;
    localparam int unsigned W_BYTES_LSB = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    function automatic logic [31:0] pack_word(input logic [3:0]  id,
                                              input logic        sof,
                                              input logic        eof,
                                              input logic [1:0]  nbytes,
                                              input logic [23:0] bytes);
        logic [31:0] w;
        w                       = '0;
        w[W_ID_LSB +: 4]        = id;
        w[W_SOF_BIT]            = sof;
        w[W_EOF_BIT]            = eof;
        w[W_NB_LSB +: 2]        = nbytes;
        w[W_BYTES_LSB +: 24]    = bytes;
        return w;
    endfunction

endpackage

// File: rtl/rx_packer_fifo.sv
// Synchronous first-word-fall-through FIFO, DEPTH x WIDTH.
//   clk_i/rst_n_i : clock, asynchronous active-low reset
//   wr_en_i/wr_data_i : write request; accepted when not full, or when full
//                       and a read is accepted in the same cycle
//   rd_en_i       : pop the head word (ignored while empty)
//   rd_data_o     : head word, forced to zero while empty
//   full_o/empty_o: occupancy flags
module rx_packer_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit separates full (MSBs differ) from empty (equal).
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_rd;
    logic             do_wr;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign do_rd = rd_en_i & ~empty_o;
    assign do_wr = wr_en_i & (~full_o | do_rd);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_rd) rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

    // Stale storage is hidden behind the empty flag, so a reset looks like
    // cleared contents without needing resettable memory.
    assign rd_data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/tjmonopix2_rx_packer.sv
// Frame packer for the TJ-Monopix2 serial link: turns decoded 8b10b bytes
// into 32-bit words {IDENTIFIER, SOF, EOF, NBYTES, 3 byte lanes} and queues
// them in a small FWFT FIFO for the readout arbiter.
//   CLK, RSTB        : byte clock, asynchronous active-low reset
//   ENABLE           : packing enable; low forces IDLE and drops pending bytes
//   DATA/DATA_K/DATA_VALID : decoded byte stream
//   FIFO_READ/FIFO_EMPTY/FIFO_DATA : FWFT read side
//   LOST_COUNT       : words dropped on a full FIFO (saturating)
//   FRAME_ERR_COUNT  : framing errors (saturating)
//   CLEAR_COUNTERS   : synchronous clear of both counters, wins over increments
module tjmonopix2_rx_packer
    import tjmonopix2_rx_pkg::*;
#(
    parameter logic [3:0]  IDENTIFIER = 4'b0001,
    parameter int unsigned DEPTH      = 16
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        ENABLE,
    input  logic [7:0]  DATA,
    input  logic        DATA_K,
    input  logic        DATA_VALID,
    input  logic        FIFO_READ,
    output logic        FIFO_EMPTY,
    output logic [31:0] FIFO_DATA,
    output logic [7:0]  LOST_COUNT,
    output logic [7:0]  FRAME_ERR_COUNT,
    input  logic        CLEAR_COUNTERS
);

    state_t      state_q, state_d;
    logic [1:0]  pend_q, pend_d;
    logic        first_q, first_d;
    logic [23:0] pack_q, pack_d;

    logic        emit;
    logic        e_sof;
    logic        e_eof;
    logic [1:0]  e_nb;
    logic [23:0] e_bytes;
    logic        err_evt;

    logic        wr_q;
    logic [31:0] word_q;
    logic        fifo_full;
    logic        lost_evt;
    logic [7:0]  lost_q;
    logic [7:0]  ferr_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (!ENABLE) begin
            state_d = IDLE;
        end else if (DATA_VALID && DATA_K) begin
            if (DATA == K_SOF)      state_d = FRAME;
            else if (DATA == K_EOF) state_d = IDLE;
        end
    end

    // ---------------- FSM: outputs / pack register next values ----------------
    always_comb begin
        pend_d  = pend_q;
        first_d = first_q;
        pack_d  = pack_q;
        emit    = 1'b0;
        e_sof   = first_q;
        e_eof   = 1'b0;
        e_nb    = pend_q;
        e_bytes = pack_q;
        err_evt = 1'b0;
        if (!ENABLE) begin
            pend_d  = '0;
            first_d = 1'b1;
            pack_d  = '0;
        end else if (DATA_VALID) begin
            if (DATA_K) begin
                case (DATA)
                    K_IDLE: begin
                    end
                    K_SOF: begin
                        // A restart flushes what is pending; a frame that has
                        // produced nothing yet still leaves a SOF marker word.
                        if (state_q == FRAME) begin
                            err_evt = 1'b1;
                            emit    = (pend_q != 2'd0) || first_q;
                        end
                        pend_d  = '0;
                        first_d = 1'b1;
                        pack_d  = '0;
                    end
                    K_EOF: begin
                        if (state_q == FRAME) begin
                            emit   = 1'b1;
                            e_eof  = 1'b1;
                            pend_d = '0;
                            pack_d = '0;
                        end else begin
                            err_evt = 1'b1;
                        end
                    end
                    default: err_evt = 1'b1;
                endcase
            end else if (state_q == IDLE) begin
                err_evt = 1'b1;
            end else if (pend_q == 2'd2) begin
                // Third byte goes straight into the word, not the register.
                emit    = 1'b1;
                e_nb    = 2'd3;
                e_bytes = {pack_q[23:8], DATA};
                pend_d  = '0;
                first_d = 1'b0;
                pack_d  = '0;
            end else begin
                pend_d = pend_q + 2'd1;
                if (pend_q == 2'd0) pack_d[23:16] = DATA;
                else                pack_d[15:8]  = DATA;
            end
        end
    end

    // ---------------- pack register, word stage, counters ----------------
    assign lost_evt = wr_q & fifo_full & ~FIFO_READ;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            pend_q  <= '0;
            first_q <= 1'b1;
            pack_q  <= '0;
            wr_q    <= 1'b0;
            word_q  <= '0;
            lost_q  <= '0;
            ferr_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            first_q <= first_d;
            pack_q  <= pack_d;
            wr_q    <= emit;
            word_q  <= pack_word(IDENTIFIER, e_sof, e_eof, e_nb, e_bytes);
            if (CLEAR_COUNTERS) begin
                lost_q <= '0;
                ferr_q <= '0;
            end else begin
                if (lost_evt && lost_q != '1) lost_q <= lost_q + 8'd1;
                if (err_evt  && ferr_q != '1) ferr_q <= ferr_q + 8'd1;
            end
        end
    end

    assign LOST_COUNT      = lost_q;
    assign FRAME_ERR_COUNT = ferr_q;

    rx_packer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i     (CLK),
        .rst_n_i   (RSTB),
        .wr_en_i   (wr_q),
        .wr_data_i (word_q),
        .rd_en_i   (FIFO_READ),
        .rd_data_o (FIFO_DATA),
        .full_o    (fifo_full),
        .empty_o   (FIFO_EMPTY)
    );

endmodule

// File: tb/tb_tjmonopix2_rx_packer.sv
module tb_tjmonopix2_rx_packer;

    localparam int unsigned DEPTH = 16;
    localparam logic [3:0]  ID    = 4'b0001;

    logic        CLK = 1'b0;
    logic        RSTB = 1'b0;
    logic        ENABLE = 1'b0;
    logic [7:0]  DATA = 8'h00;
    logic        DATA_K = 1'b0;
    logic        DATA_VALID = 1'b0;
    logic        FIFO_READ = 1'b0;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic [7:0]  LOST_COUNT;
    logic [7:0]  FRAME_ERR_COUNT;
    logic        CLEAR_COUNTERS = 1'b0;

    tjmonopix2_rx_packer #(
        .IDENTIFIER (ID),
        .DEPTH      (DEPTH)
    ) dut (
        .CLK             (CLK),
        .RSTB            (RSTB),
        .ENABLE          (ENABLE),
        .DATA            (DATA),
        .DATA_K          (DATA_K),
        .DATA_VALID      (DATA_VALID),
        .FIFO_READ       (FIFO_READ),
        .FIFO_EMPTY      (FIFO_EMPTY),
        .FIFO_DATA       (FIFO_DATA),
        .LOST_COUNT      (LOST_COUNT),
        .FRAME_ERR_COUNT (FRAME_ERR_COUNT),
        .CLEAR_COUNTERS  (CLEAR_COUNTERS)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit           m_in_frame;
    bit           m_first;
    byte unsigned m_bytes[$];
    logic [31:0]  m_fifo[$];
    bit           m_pw_v;
    logic [31:0]  m_pw;
    int unsigned  m_lost;
    int unsigned  m_ferr;

    function automatic logic [31:0] mk_word(input bit sof, input bit eof, input byte unsigned b[$]);
        logic [31:0] w;
        w = {ID, 28'h0};
        w = w | (32'(sof) << 27) | (32'(eof) << 26) | (32'(b.size()) << 24);
        for (int i = 0; i < b.size(); i++) w = w | (32'(b[i]) << (16 - 8 * i));
        return w;
    endfunction

    task automatic model_reset();
        m_in_frame = 0;
        m_first    = 1;
        m_bytes.delete();
        m_fifo.delete();
        m_pw_v = 0;
        m_pw   = '0;
        m_lost = 0;
        m_ferr = 0;
    endtask

    // Effect of one clock edge: the word emitted on the previous edge reaches
    // the FIFO now; the byte sampled now may emit a word for the next edge.
    task automatic model_edge(input bit en, input bit valid, input bit k,
                              input byte unsigned d, input bit rd, input bit clr);
        bit          lost_evt = 0;
        bit          err_evt  = 0;
        bit          emit     = 0;
        logic [31:0] ew       = '0;
        if (rd && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (m_pw_v) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pw);
            else lost_evt = 1;
        end
        if (!en) begin
            m_in_frame = 0;
            m_bytes.delete();
        end else if (valid) begin
            if (k) begin
                case (d)
                    8'hBC: begin end
                    8'h3C: begin
                        if (m_in_frame) begin
                            err_evt = 1;
                            if (m_bytes.size() > 0 || m_first) begin
                                emit = 1;
                                ew = mk_word(m_first, 0, m_bytes);
                            end
                        end
                        m_in_frame = 1;
                        m_first = 1;
                        m_bytes.delete();
                    end
                    8'h1C: begin
                        if (m_in_frame) begin
                            emit = 1;
                            ew = mk_word(m_first, 1, m_bytes);
                            m_in_frame = 0;
                            m_bytes.delete();
                        end else err_evt = 1;
                    end
                    default: err_evt = 1;
                endcase
            end else if (!m_in_frame) begin
                err_evt = 1;
            end else begin
                m_bytes.push_back(d);
                if (m_bytes.size() == 3) begin
                    emit = 1;
                    ew = mk_word(m_first, 0, m_bytes);
                    m_first = 0;
                    m_bytes.delete();
                end
            end
        end
        m_pw_v = emit;
        m_pw   = ew;
        if (clr) begin
            m_lost = 0;
            m_ferr = 0;
        end else begin
            if (lost_evt && m_lost < 255) m_lost++;
            if (err_evt && m_ferr < 255) m_ferr++;
        end
    endtask

    task automatic model_compare();
        check("empty", FIFO_EMPTY, m_fifo.size() == 0);
        if (m_fifo.size() > 0) check("head", FIFO_DATA, m_fifo[0]);
        check("lost", LOST_COUNT, m_lost);
        check("ferr", FRAME_ERR_COUNT, m_ferr);
    endtask

    // Drive one cycle's inputs, step the model on the edge, compare at negedge.
    task automatic cycle(input bit en, input bit valid, input bit k,
                         input byte unsigned d, input bit rd, input bit clr);
        ENABLE = en; DATA_VALID = valid; DATA_K = k; DATA = d;
        FIFO_READ = rd; CLEAR_COUNTERS = clr;
        @(posedge CLK);
        model_edge(en, valid, k, d, rd, clr);
        @(negedge CLK);
        model_compare();
    endtask

    task automatic send_k(input byte unsigned d);  cycle(1, 1, 1, d, 0, 0); endtask
    task automatic send_d(input byte unsigned d);  cycle(1, 1, 0, d, 0, 0); endtask
    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(1, 0, 0, 8'h00, 0, 0);
    endtask
    task automatic clear();                      cycle(1, 0, 0, 8'h00, 0, 1); endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        check({tag, "_ne"}, FIFO_EMPTY, 1'b0);
        check(tag, FIFO_DATA, exp);
        cycle(1, 0, 0, 8'h00, 1, 0);
    endtask

    logic [31:0] exp_w;

    initial begin
        model_reset();
        #12;
        check("rst_empty", FIFO_EMPTY, 1'b1);
        check("rst_data", FIFO_DATA, 32'h0);
        check("rst_lost", LOST_COUNT, 8'h0);
        check("rst_ferr", FRAME_ERR_COUNT, 8'h0);
        @(negedge CLK);
        RSTB = 1'b1;

        // Frame with four bytes; latency of the third-byte word.
        send_k(8'h3C); send_d(8'h11); send_d(8'h22); send_d(8'h33);
        check("lat_e0", FIFO_EMPTY, 1'b1);
        send_d(8'h44);
        check("lat_e1", FIFO_EMPTY, 1'b0);
        send_k(8'h1C); idle(2);
        pop_expect("t1_w0", 32'h1B112233);
        pop_expect("t1_w1", 32'h15440000);
        check("t1_drained", FIFO_EMPTY, 1'b1);

        // Empty frame.
        send_k(8'h3C); send_k(8'h1C); idle(2);
        pop_expect("t2_w0", 32'h1C000000);

        // SOF restart inside a frame.
        clear();
        send_k(8'h3C); send_d(8'hAA); send_k(8'h3C); send_d(8'hBB); send_k(8'h1C); idle(2);
        check("t3_ferr", FRAME_ERR_COUNT, 8'd1);
        pop_expect("t3_w0", 32'h19AA0000);
        pop_expect("t3_w1", 32'h1DBB0000);

        // Errors while idle, idle K ignored.
        clear();
        send_d(8'h5A); send_k(8'hBC); send_k(8'h5C); idle(2);
        check("t4_ferr", FRAME_ERR_COUNT, 8'd2);
        check("t4_empty", FIFO_EMPTY, 1'b1);

        // Overflow: 10 three-byte frames = 20 words into a 16-deep FIFO.
        clear();
        for (int f = 0; f < 10; f++) begin
            send_k(8'h3C);
            for (int b = 0; b < 3; b++) send_d(byte'(f * 3 + b + 1));
            send_k(8'h1C);
        end
        idle(2);
        check("t5_lost", LOST_COUNT, 8'd4);
        for (int n = 0; n < 16; n++) begin
            if (n % 2 == 0) begin
                exp_w = 32'h1B000000 | (32'(n / 2 * 3 + 1) << 16)
                                     | (32'(n / 2 * 3 + 2) << 8) | 32'(n / 2 * 3 + 3);
            end else begin
                exp_w = 32'h14000000;
            end
            pop_expect("t5_pop", exp_w);
        end
        check("t5_drained", FIFO_EMPTY, 1'b1);

        // ENABLE drop mid-frame.
        clear();
        send_k(8'h3C); send_d(8'h66);
        cycle(0, 1, 0, 8'h67, 0, 0);
        send_k(8'h1C); idle(2);
        check("t6_no_word", FIFO_EMPTY, 1'b1);
        check("t6_ferr", FRAME_ERR_COUNT, 8'd1);
        send_k(8'h3C); send_d(8'h77); send_k(8'h1C); idle(2);
        pop_expect("t6_w0", 32'h1D770000);

        // Asynchronous reset mid-frame with a word still queued.
        send_k(8'h3C); send_d(8'h81); send_d(8'h82); send_d(8'h83); send_d(8'h88); idle(1);
        RSTB = 1'b0;
        #1;
        check("t7_empty", FIFO_EMPTY, 1'b1);
        check("t7_data", FIFO_DATA, 32'h0);
        check("t7_lost", LOST_COUNT, 8'h0);
        check("t7_ferr", FRAME_ERR_COUNT, 8'h0);
        model_reset();
        #1;
        RSTB = 1'b1;
        send_d(8'h99); send_k(8'h3C); send_d(8'h12); send_d(8'h34); send_k(8'h1C); idle(2);
        pop_expect("t7_w0", 32'h1E123400);

        // Error counter saturation, then clear beats a same-cycle increment.
        clear();
        for (int i = 0; i < 260; i++) send_d(8'hEE);
        check("sat_ferr", FRAME_ERR_COUNT, 8'd255);
        cycle(1, 1, 0, 8'hEE, 0, 1);
        check("clr_prio", FRAME_ERR_COUNT, 8'd0);

        // Lost counter saturation.
        send_k(8'h3C);
        for (int i = 0; i < 3 * (DEPTH + 262); i++) send_d(byte'(i));
        idle(2);
        check("sat_lost", LOST_COUNT, 8'd255);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1, 0, 0, 8'h00, 1, 1);

        // Randomised traffic against the model.
        for (int blk = 0; blk < 20; blk++) begin
            int unsigned rd_pct;
            rd_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
            for (int i = 0; i < 200; i++) begin
                int unsigned r;
                bit en, valid, k, rd, clr;
                byte unsigned d;
                en    = ($urandom_range(0, 99) >= 2);
                valid = ($urandom_range(0, 99) < 85);
                rd    = ($urandom_range(0, 99) < rd_pct);
                clr   = ($urandom_range(0, 99) < 1);
                r     = $urandom_range(0, 99);
                k     = 1;
                if (r < 55) begin
                    k = 0;
                    d = byte'($urandom);
                end else if (r < 67) d = 8'h3C;
                else if (r < 79)     d = 8'h1C;
                else if (r < 92)     d = 8'hBC;
                else begin
                    case ($urandom_range(0, 3))
                        0: d = 8'h5C;
                        1: d = 8'h7C;
                        2: d = 8'h9C;
                        default: d = 8'hF7;
                    endcase
                end
                cycle(en, valid, k, d, rd, clr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
